xif_coproc_alu_tracker: RTL and testbench
=========================================

Name: xif_coproc_alu_tracker

Overview:
- Coprocessor-side consumer of the CORE-V XIF issue, commit and result channels. Sits directly downstream of the host's XIF ports.
- Decodes a small custom-0 ALU extension and holds accepted instructions in an in-order tracking buffer until their commit arrives.
- Computes results and returns committed ones over the result channel; drops killed ones without a result.

Parameters:
- X_ID_WIDTH, 4, width of the instruction id field.
- X_RFR_WIDTH, 32, width of each source operand; fixed at XLEN=32.
- DEPTH, 4, tracking buffer entries; power of 2, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  issue handshake ready
- issue_instr_i  in  32  offloaded instruction
- issue_id_i  in  X_ID_WIDTH  instruction id
- issue_rs_i  in  2*X_RFR_WIDTH  {rs2, rs1}
- issue_rs_valid_i  in  2  operand validity, bit0=rs1
- issue_accept_o  out  1  instruction accepted
- issue_writeback_o  out  1  accepted instruction will write rd
- commit_valid_i  in  1  commit transaction valid
- commit_id_i  in  X_ID_WIDTH  committed id
- commit_kill_i  in  1  kill instead of commit
- result_valid_o  out  1  result valid
- result_ready_i  in  1  core accepts result
- result_id_o  out  X_ID_WIDTH  id of result
- result_data_o  out  32  write data
- result_rd_o  out  5  destination register
- result_we_o  out  1  register write enable
- result_exc_o  out  1  tied 0

Behaviour:
- Decode:
  - hit = instr[6:0]==7'b0001011 and funct3 in {000 ADD, 001 XOR, 010 ROL}.
  - ROL: rs1 rotated left by rs2[4:0]. ADD wraps modulo 2^32.
  - Decode is combinational; accept/writeback are valid only in the issue handshake cycle.
- Issue handshake:
  - Transfer occurs when issue_valid_i && issue_ready_o.
  - issue_ready_o = !hit || (!full && &issue_rs_valid_i).
  - Non-hit: ready=1, accept=0, writeback=0; nothing is stored.
  - Hit: accept=1, writeback=(rd!=0). The entry is written at tail with {id, rd, op, rs1, rs2}, state=ISSUED; tail increments.
  - issue_accept_o and issue_writeback_o are 0 whenever issue_valid_i=0.
- Entry states: FREE, ISSUED, COMMITTED, KILLED.
- Commit:
  - On commit_valid_i, search ISSUED entries for the matching id.
  - kill=0 moves the entry to COMMITTED; kill=1 moves it to KILLED.
  - No match: ignored (covers rejected instructions).
  - A commit in the same cycle as the issue handshake of the same id applies to the newly written entry.
  - Ids of in-flight entries are unique. A duplicate is a core protocol error, flagged by an assertion.
- Retire, head entry only, in order:
  - KILLED: freed in 1 cycle, no result, head increments.
  - COMMITTED: result_valid_o=1 with stored id and rd, computed data, result_we_o=(rd!=0), result_exc_o=0.
  - On result_ready_i the entry is freed and head increments.
  - result_* outputs stay stable while valid && !ready.
  - ISSUED or FREE: result_valid_o=0.
- Latency: an issue and commit in cycle N give result_valid_o at N+1 at the earliest.
- Throughput: 1 issue, 1 commit and 1 retire per cycle, concurrently.
- Full/empty:
  - count in 0..DEPTH; full when count==DEPTH.
  - Retire and issue in the same cycle while full: issue_ready_o still uses the registered full, so that issue stalls for one cycle.
  - Pointers wrap modulo DEPTH.
- Reset, applied at any time including mid-operation:
  - All entries FREE, head=tail=count=0.
  - result_valid_o=0, result_id_o/data/rd/we=0.
  - issue_ready_o=1 (empty), accept/writeback=0 when not valid.
  - In-flight instructions are discarded.

Test Plan:
- Issue ADD id=3, rs1=0xFFFF_FFFF, rs2=2, rd=5; commit id=3 kill=0 same cycle -> accept=1, writeback=1; next cycle result valid, id=3, data=0x0000_0001, rd=5, we=1.
- Issue opcode 0110011 (non-custom) -> ready=1, accept=0, no entry stored; a later commit for that id is ignored and no result appears.
- Issue ROL rs1=0x8000_0001, rs2=0x24 (shift 4), rd=0; commit -> data=0x0000_0018, we=0, writeback=0.
- Issue ids 1,2,3; commit 1 ok, 2 kill, 3 ok; hold result_ready_i=0 for 3 cycles -> id1 held stable; after ready, id2 is skipped and id3 is delivered; exactly 2 results total.
- Fill DEPTH=4 with no commits -> issue_ready_o=0 for a hit; a non-hit still completes with accept=0; commit and retire one -> ready returns to 1 the cycle after the retire.
- Assert rst_i with 2 committed entries and result_valid_o=1 -> the next cycle has result_valid_o=0 and issue_ready_o=1; no stale result after release.

Source files
------------

// File: rtl/xif_coproc_alu_tracker_if.sv
// XIF issue/commit/result bundle between host core and the ALU coprocessor.
// Latency: none, wires only.
// Backpressure: issue_ready_o and result_ready_i carry the two handshakes.
interface xif_coproc_alu_tracker_if #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFR_WIDTH = 32
);
  // issue channel
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [31:0]              issue_instr_i;
  logic [X_ID_WIDTH-1:0]    issue_id_i;
  logic [2*X_RFR_WIDTH-1:0] issue_rs_i;
  logic [1:0]               issue_rs_valid_i;
  logic                     issue_accept_o;
  logic                     issue_writeback_o;
  // commit channel
  logic                     commit_valid_i;
  logic [X_ID_WIDTH-1:0]    commit_id_i;
  logic                     commit_kill_i;
  // result channel
  logic                     result_valid_o;
  logic                     result_ready_i;
  logic [X_ID_WIDTH-1:0]    result_id_o;
  logic [31:0]              result_data_o;
  logic [4:0]               result_rd_o;
  logic                     result_we_o;
  logic                     result_exc_o;

  // host core side
  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    output commit_valid_i, commit_id_i, commit_kill_i,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, result_exc_o,
    output result_ready_i
  );

  // coprocessor side
  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, result_exc_o,
    input  result_ready_i
  );
endinterface

// File: rtl/xif_coproc_alu_tracker.sv
// Custom-0 ALU coprocessor: decode, in-order tracking buffer, commit/kill, result return.
// Latency: issue+commit in cycle N gives result_valid_o in N+1 at the earliest.
// Backpressure: issue stalls on registered full or missing operands; head holds while result_ready_i=0.
module xif_coproc_alu_tracker #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input logic clk_i,
  input logic rst_i,
  xif_coproc_alu_tracker_if.slave xif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_ISSUED    = 2'd1,
    ST_COMMITTED = 2'd2,
    ST_KILLED    = 2'd3
  } st_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_XOR = 2'd1,
    OP_ROL = 2'd2
  } op_e;

  typedef struct packed {
    st_e                    st;
    logic [X_ID_WIDTH-1:0]  id;
    logic [4:0]             rd;
    op_e                    op;
    logic [X_RFR_WIDTH-1:0] rs1;
    logic [X_RFR_WIDTH-1:0] rs2;
  } entry_t;

  entry_t         ent_q [DEPTH];
  entry_t         ent_d [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [4:0]     rd;
  logic           hit;
  logic           full;
  logic           issue_fire;
  logic           same_cycle_commit;
  logic           retire;
  logic           dup_id;
  entry_t         head_ent;
  logic           unused_instr;

  assign opcode = xif.issue_instr_i[6:0];
  assign rd     = xif.issue_instr_i[11:7];
  assign funct3 = xif.issue_instr_i[14:12];
  assign unused_instr = ^xif.issue_instr_i[31:15];

  assign hit  = (opcode == 7'b0001011) && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
  assign full = (count_q == CW'(DEPTH));

  // Non-hits never stall; hits need space and both operands.
  assign xif.issue_ready_o     = !hit || (!full && (&xif.issue_rs_valid_i));
  assign issue_fire            = xif.issue_valid_i && xif.issue_ready_o && hit;
  assign xif.issue_accept_o    = issue_fire;
  assign xif.issue_writeback_o = issue_fire && (rd != 5'd0);

  assign same_cycle_commit = xif.commit_valid_i && issue_fire && (xif.commit_id_i == xif.issue_id_i);

  assign head_ent = ent_q[head_q];
  assign retire   = (head_ent.st == ST_KILLED) ||
                    ((head_ent.st == ST_COMMITTED) && xif.result_ready_i);

  function automatic logic [31:0] alu(input op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] rot;
    rot = {a, a} << b[4:0];
    case (op)
      OP_ADD:  alu = a + b;
      OP_XOR:  alu = a ^ b;
      OP_ROL:  alu = rot[63:32];
      default: alu = 32'd0;
    endcase
  endfunction

  // Result channel is driven straight from the head entry, which is frozen while waiting.
  always_comb begin
    xif.result_valid_o = (head_ent.st == ST_COMMITTED);
    xif.result_id_o    = '0;
    xif.result_data_o  = '0;
    xif.result_rd_o    = '0;
    xif.result_we_o    = 1'b0;
    xif.result_exc_o   = 1'b0;
    if (head_ent.st == ST_COMMITTED) begin
      xif.result_id_o   = head_ent.id;
      xif.result_data_o = alu(head_ent.op, head_ent.rs1, head_ent.rs2);
      xif.result_rd_o   = head_ent.rd;
      xif.result_we_o   = (head_ent.rd != 5'd0);
    end
  end

  // Next-state of the buffer: commit/kill search, tail write, head free.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (xif.commit_valid_i && ent_q[i].st == ST_ISSUED && ent_q[i].id == xif.commit_id_i) begin
        ent_d[i].st = xif.commit_kill_i ? ST_KILLED : ST_COMMITTED;
      end
    end
    if (issue_fire) begin
      ent_d[tail_q].id  = xif.issue_id_i;
      ent_d[tail_q].rd  = rd;
      ent_d[tail_q].op  = op_e'(funct3[1:0]);
      ent_d[tail_q].rs1 = xif.issue_rs_i[X_RFR_WIDTH-1:0];
      ent_d[tail_q].rs2 = xif.issue_rs_i[2*X_RFR_WIDTH-1:X_RFR_WIDTH];
      if (same_cycle_commit) begin
        ent_d[tail_q].st = xif.commit_kill_i ? ST_KILLED : ST_COMMITTED;
      end else begin
        ent_d[tail_q].st = ST_ISSUED;
      end
    end
    if (retire) begin
      ent_d[head_q].st = ST_FREE;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2.
  always_comb begin
    tail_d  = issue_fire ? tail_q + PW'(1) : tail_q;
    head_d  = retire ? head_q + PW'(1) : head_q;
    count_d = count_q + CW'(issue_fire) - CW'(retire);
  end

  // State registers with synchronous reset discarding all in-flight work.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Any live entry already using the id being issued.
  always_comb begin
    dup_id = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].st != ST_FREE && ent_q[i].id == xif.issue_id_i) begin
        dup_id = 1'b1;
      end
    end
  end

  a_unique_id: assert property (@(posedge clk_i) disable iff (rst_i) issue_fire |-> !dup_id)
    else $error("duplicate in-flight XIF id issued");

endmodule

// File: tb/tb_xif_coproc_alu_tracker.sv
// Directed bench for the XIF ALU coprocessor tracker.
// Latency: checks N+1 result timing and hold behaviour.
// Backpressure: exercises result_ready_i stalls and full-buffer issue stalls.
module tb_xif_coproc_alu_tracker;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk_i = ~clk_i;

  xif_coproc_alu_tracker_if #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32)) xif ();

  xif_coproc_alu_tracker #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .DEPTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .xif   (xif)
  );

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_XOR = 3'b001;
  localparam logic [2:0] F_ROL = 3'b010;

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, 7'b0001011};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_issue(input logic [31:0] instr, input logic [3:0] id,
                           input logic [31:0] rs1, input logic [31:0] rs2);
    xif.issue_valid_i    = 1'b1;
    xif.issue_instr_i    = instr;
    xif.issue_id_i       = id;
    xif.issue_rs_i       = {rs2, rs1};
    xif.issue_rs_valid_i = 2'b11;
  endtask

  task automatic clr_issue();
    xif.issue_valid_i    = 1'b0;
    xif.issue_instr_i    = '0;
    xif.issue_id_i       = '0;
    xif.issue_rs_i       = '0;
    xif.issue_rs_valid_i = 2'b00;
  endtask

  task automatic set_commit(input logic [3:0] id, input logic kill);
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = id;
    xif.commit_kill_i  = kill;
  endtask

  task automatic clr_commit();
    xif.commit_valid_i = 1'b0;
    xif.commit_id_i    = '0;
    xif.commit_kill_i  = 1'b0;
  endtask

  task automatic test_reset();
    clr_issue();
    clr_commit();
    xif.result_ready_i = 1'b0;
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    step();
    checks++; if (xif.issue_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", xif.issue_ready_o); else passed++;
    checks++; if (xif.result_valid_o !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", xif.result_valid_o); else passed++;
    checks++; if ({xif.result_id_o, xif.result_data_o, xif.result_rd_o, xif.result_we_o} !== 42'd0)
      $display("FAIL reset_rbus: got %h/%h/%h/%b want 0", xif.result_id_o, xif.result_data_o, xif.result_rd_o, xif.result_we_o); else passed++;
    checks++; if ({xif.issue_accept_o, xif.issue_writeback_o} !== 2'b00)
      $display("FAIL reset_accept: got %b%b want 00", xif.issue_accept_o, xif.issue_writeback_o); else passed++;
  endtask

  task automatic test_add();
    set_issue(mk(F_ADD, 5'd5), 4'd3, 32'hFFFF_FFFF, 32'd2);
    set_commit(4'd3, 1'b0);
    #1;
    checks++; if ({xif.issue_ready_o, xif.issue_accept_o, xif.issue_writeback_o} !== 3'b111)
      $display("FAIL add_issue: got rdy/acc/wb=%b%b%b want 111", xif.issue_ready_o, xif.issue_accept_o, xif.issue_writeback_o); else passed++;
    step();
    clr_issue();
    clr_commit();
    checks++; if (xif.result_valid_o !== 1'b1) $display("FAIL add_latency: got valid %b want 1", xif.result_valid_o); else passed++;
    checks++; if (xif.result_id_o !== 4'd3) $display("FAIL add_id: got %0d want 3", xif.result_id_o); else passed++;
    checks++; if (xif.result_data_o !== 32'h0000_0001) $display("FAIL add_data: got %h want 00000001", xif.result_data_o); else passed++;
    checks++; if ({xif.result_rd_o, xif.result_we_o, xif.result_exc_o} !== {5'd5, 1'b1, 1'b0})
      $display("FAIL add_rd_we: got rd=%0d we=%b exc=%b want 5/1/0", xif.result_rd_o, xif.result_we_o, xif.result_exc_o); else passed++;
    xif.result_ready_i = 1'b1;
    step();
    xif.result_ready_i = 1'b0;
    checks++; if (xif.result_valid_o !== 1'b0) $display("FAIL add_retired: got valid %b want 0", xif.result_valid_o); else passed++;
  endtask

  task automatic test_nonhit();
    int seen;
    set_issue({17'd0, 3'b000, 5'd1, 7'b0110011}, 4'd7, 32'd1, 32'd1);
    #1;
    checks++; if ({xif.issue_ready_o, xif.issue_accept_o, xif.issue_writeback_o} !== 3'b100)
      $display("FAIL nonhit_issue: got rdy/acc/wb=%b%b%b want 100", xif.issue_ready_o, xif.issue_accept_o, xif.issue_writeback_o); else passed++;
    step();
    clr_issue();
    set_commit(4'd7, 1'b0);
    xif.result_ready_i = 1'b1;
    step();
    clr_commit();
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (xif.result_valid_o === 1'b1) seen++;
      step();
    end
    xif.result_ready_i = 1'b0;
    checks++; if (seen !== 0) $display("FAIL nonhit_no_result: got %0d results want 0", seen); else passed++;
  endtask

  task automatic test_rol();
    set_issue(mk(F_ROL, 5'd0), 4'd4, 32'h8000_0001, 32'h0000_0024);
    set_commit(4'd4, 1'b0);
    #1;
    checks++; if ({xif.issue_accept_o, xif.issue_writeback_o} !== 2'b10)
      $display("FAIL rol_issue: got acc/wb=%b%b want 10", xif.issue_accept_o, xif.issue_writeback_o); else passed++;
    step();
    clr_issue();
    clr_commit();
    checks++; if ({xif.result_valid_o, xif.result_id_o} !== {1'b1, 4'd4})
      $display("FAIL rol_valid_id: got %b/%0d want 1/4", xif.result_valid_o, xif.result_id_o); else passed++;
    checks++; if (xif.result_data_o !== 32'h0000_0018) $display("FAIL rol_data: got %h want 00000018", xif.result_data_o); else passed++;
    checks++; if ({xif.result_rd_o, xif.result_we_o} !== 6'd0)
      $display("FAIL rol_rd_we: got rd=%0d we=%b want 0/0", xif.result_rd_o, xif.result_we_o); else passed++;
    xif.result_ready_i = 1'b1;
    step();
    xif.result_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ids [4];
    logic [31:0] dat [4];
    int n;
    set_issue(mk(F_XOR, 5'd1), 4'd1, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    step();
    set_issue(mk(F_ADD, 5'd2), 4'd2, 32'd1, 32'd1);
    step();
    set_issue(mk(F_XOR, 5'd3), 4'd3, 32'hAAAA_5555, 32'h0000_FFFF);
    step();
    clr_issue();
    xif.result_ready_i = 1'b0;
    set_commit(4'd1, 1'b0);
    step();
    for (int h = 0; h < 3; h++) begin
      if (h == 0) set_commit(4'd2, 1'b1);
      else if (h == 1) set_commit(4'd3, 1'b0);
      else clr_commit();
      checks++; if ({xif.result_valid_o, xif.result_id_o, xif.result_data_o, xif.result_rd_o} !== {1'b1, 4'd1, 32'hFFFF_FFFF, 5'd1})
        $display("FAIL hold_%0d: got v=%b id=%0d d=%h rd=%0d want 1/1/ffffffff/1", h,
                 xif.result_valid_o, xif.result_id_o, xif.result_data_o, xif.result_rd_o); else passed++;
      step();
    end
    clr_commit();
    xif.result_ready_i = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (xif.result_valid_o === 1'b1) begin
        if (n < 4) begin
          ids[n] = xif.result_id_o;
          dat[n] = xif.result_data_o;
        end
        n++;
      end
      step();
    end
    xif.result_ready_i = 1'b0;
    checks++; if (n !== 2) $display("FAIL order_count: got %0d results want 2", n); else passed++;
    if (n >= 2) begin
      checks++; if (ids[0] !== 4'd1 || ids[1] !== 4'd3)
        $display("FAIL order_ids: got %0d,%0d want 1,3", ids[0], ids[1]); else passed++;
      checks++; if (dat[1] !== 32'hAAAA_AAAA) $display("FAIL order_data3: got %h want aaaaaaaa", dat[1]); else passed++;
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      set_issue(mk(F_ADD, 5'd1), 4'(8 + k), 32'd1, 32'd1);
      step();
    end
    set_issue(mk(F_ADD, 5'd1), 4'd12, 32'd1, 32'd1);
    #1;
    checks++; if ({xif.issue_ready_o, xif.issue_accept_o} !== 2'b00)
      $display("FAIL full_stall: got rdy/acc=%b%b want 00", xif.issue_ready_o, xif.issue_accept_o); else passed++;
    set_issue({17'd0, 3'b000, 5'd1, 7'b0110011}, 4'd12, 32'd1, 32'd1);
    #1;
    checks++; if ({xif.issue_ready_o, xif.issue_accept_o, xif.issue_writeback_o} !== 3'b100)
      $display("FAIL full_nonhit: got rdy/acc/wb=%b%b%b want 100", xif.issue_ready_o, xif.issue_accept_o, xif.issue_writeback_o); else passed++;
    step();
    set_issue(mk(F_ADD, 5'd1), 4'd13, 32'd5, 32'd6);
    set_commit(4'd8, 1'b0);
    step();
    clr_commit();
    xif.result_ready_i = 1'b1;
    checks++; if ({xif.result_valid_o, xif.result_id_o, xif.result_data_o} !== {1'b1, 4'd8, 32'd2})
      $display("FAIL full_head_result: got v=%b id=%0d d=%h want 1/8/2", xif.result_valid_o, xif.result_id_o, xif.result_data_o); else passed++;
    checks++; if (xif.issue_ready_o !== 1'b0) $display("FAIL full_retire_cycle_ready: got %b want 0", xif.issue_ready_o); else passed++;
    step();
    xif.result_ready_i = 1'b0;
    checks++; if (xif.issue_ready_o !== 1'b1) $display("FAIL full_ready_after_retire: got %b want 1", xif.issue_ready_o); else passed++;
    step();
    clr_issue();
    set_commit(4'd9, 1'b1);  step();
    set_commit(4'd10, 1'b1); step();
    set_commit(4'd11, 1'b1); step();
    set_commit(4'd13, 1'b0); step();
    clr_commit();
    checks++; if ({xif.result_valid_o, xif.result_id_o, xif.result_data_o} !== {1'b1, 4'd13, 32'd11})
      $display("FAIL full_last_result: got v=%b id=%0d d=%h want 1/13/b", xif.result_valid_o, xif.result_id_o, xif.result_data_o); else passed++;
    xif.result_ready_i = 1'b1;
    step();
    xif.result_ready_i = 1'b0;
    checks++; if ({xif.result_valid_o, xif.issue_ready_o} !== 2'b01)
      $display("FAIL full_drained: got v=%b rdy=%b want 0/1", xif.result_valid_o, xif.issue_ready_o); else passed++;
  endtask

  task automatic test_reset_mid();
    set_issue(mk(F_ADD, 5'd6), 4'd5, 32'd3, 32'd4);
    set_commit(4'd5, 1'b0);
    step();
    set_issue(mk(F_ADD, 5'd7), 4'd6, 32'd10, 32'd20);
    set_commit(4'd6, 1'b0);
    step();
    clr_issue();
    clr_commit();
    checks++; if ({xif.result_valid_o, xif.result_id_o} !== {1'b1, 4'd5})
      $display("FAIL rstmid_pre: got v=%b id=%0d want 1/5", xif.result_valid_o, xif.result_id_o); else passed++;
    rst_i = 1'b1;
    step();
    checks++; if ({xif.result_valid_o, xif.issue_ready_o} !== 2'b01)
      $display("FAIL rstmid_flush: got v=%b rdy=%b want 0/1", xif.result_valid_o, xif.issue_ready_o); else passed++;
    checks++; if ({xif.result_id_o, xif.result_data_o, xif.result_rd_o, xif.result_we_o} !== 42'd0)
      $display("FAIL rstmid_rbus: got %h/%h/%h/%b want 0", xif.result_id_o, xif.result_data_o, xif.result_rd_o, xif.result_we_o); else passed++;
    rst_i = 1'b0;
    xif.result_ready_i = 1'b1;
    step();
    step();
    checks++; if (xif.result_valid_o !== 1'b0) $display("FAIL rstmid_stale: got v=%b want 0", xif.result_valid_o); else passed++;
    xif.result_ready_i = 1'b0;
    set_issue(mk(F_XOR, 5'd2), 4'd5, 32'h1234_5678, 32'hFFFF_0000);
    set_commit(4'd5, 1'b0);
    step();
    clr_issue();
    clr_commit();
    checks++; if ({xif.result_valid_o, xif.result_id_o, xif.result_data_o} !== {1'b1, 4'd5, 32'hEDCB_5678})
      $display("FAIL rstmid_reuse: got v=%b id=%0d d=%h want 1/5/edcb5678", xif.result_valid_o, xif.result_id_o, xif.result_data_o); else passed++;
    xif.result_ready_i = 1'b1;
    step();
    xif.result_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_nonhit();
    test_rol();
    test_back_to_back();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
